// File: rtl/seq_control_unit_if.sv
// Controller <-> datapath/memory bundle; master = control unit, slave = datapath and memory side.
interface seq_control_unit_if #(
  parameter int DATA_W = 8
);
  logic [1:0]          flags;
  logic [7:0]          ctrl_flags;
  logic [1:0]          cond_sel;
  logic [DATA_W-1:0]   reg_o1;
  logic [DATA_W-1:0]   reg_o2;
  logic [DATA_W-1:0]   alu_out;
  logic [2*DATA_W-1:0] mem_out;
  logic                mem_ready;
  logic                mem_req;
  logic [DATA_W-1:0]   mem_addr;
  logic [2*DATA_W-1:0] mem_in;
  logic                mem_we;
  logic [2*DATA_W-1:0] inst;
  logic [DATA_W-1:0]   reg_in;
  logic [DATA_W-1:0]   alu_b;
  logic                reg_we;
  logic [DATA_W-1:0]   pc;

  modport master (
    input  flags, ctrl_flags, cond_sel, reg_o1, reg_o2, alu_out, mem_out, mem_ready,
    output mem_req, mem_addr, mem_in, mem_we, inst, reg_in, alu_b, reg_we, pc
  );

  modport slave (
    output flags, ctrl_flags, cond_sel, reg_o1, reg_o2, alu_out, mem_out, mem_ready,
    input  mem_req, mem_addr, mem_in, mem_we, inst, reg_in, alu_b, reg_we, pc
  );
endinterface

// File: rtl/seq_control_unit.sv
// Fetch/execute controller: 2 cycles per instruction, memory ops stall on mem_ready low.
// Optional HALT state enabled by macro SEQ_CU_HALT_EN (adds halt/halted ports).
module seq_control_unit #(
  parameter int DATA_W     = 8,
  parameter int IMM_SEXT_W = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef SEQ_CU_HALT_EN
  input  logic halt,
  output logic halted,
`endif
  seq_control_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1
`ifdef SEQ_CU_HALT_EN
    , ST_HALT = 2'd2
`endif
  } state_t;

  localparam logic [DATA_W-2:0] PC_ONE = 1;

  state_t              r_state;
  logic [DATA_W-2:0]   r_pc;
  logic [2*DATA_W-1:0] r_inst;

  logic              w_cond, w_adi, w_ipc, w_wpc, w_spc, w_we, w_re, w_ldi;
  logic              w_mem_op, w_commit, w_sel, w_taken;
  logic [DATA_W-1:0] w_imm, w_pc_byte;
  logic              w_unused;

  assign {w_cond, w_adi, w_ipc, w_wpc, w_spc, w_we, w_re, w_ldi} = bus.ctrl_flags;
  assign w_mem_op  = w_we | w_re;
  assign w_imm     = r_inst[DATA_W-1:0];
  assign w_pc_byte = {r_pc, 1'b0};
  assign w_unused  = bus.alu_out[0];

  always_comb begin
    w_sel = 1'b0;
    case (bus.cond_sel)
      2'd0:    w_sel = bus.flags[0];
      2'd1:    w_sel = ~bus.flags[0];
      2'd2:    w_sel = bus.flags[1];
      default: w_sel = ~bus.flags[1];
    endcase
  end
  assign w_taken = ~w_cond | w_sel;

  // Commit: first EXEC cycle for register ops, the mem_ready cycle for memory ops.
  assign w_commit = ~rst && (r_state == ST_EXEC) && (~w_mem_op || bus.mem_ready);

  assign bus.mem_req  = ~rst && ((r_state == ST_FETCH) || ((r_state == ST_EXEC) && w_mem_op));
  assign bus.mem_addr = (r_state == ST_EXEC) ? bus.reg_o1 : w_pc_byte;
  assign bus.mem_we   = w_commit & w_we;
  assign bus.reg_we   = w_commit & ~w_we;
  assign bus.inst     = r_inst;
  assign bus.pc       = w_pc_byte;
  assign bus.alu_b    = w_adi ? {{(DATA_W-IMM_SEXT_W){r_inst[IMM_SEXT_W-1]}}, r_inst[IMM_SEXT_W-1:0]}
                              : bus.reg_o2;

  always_comb begin
    bus.reg_in = bus.alu_out;
    if (w_spc)
      bus.reg_in = w_pc_byte;
    else if (w_ldi)
      bus.reg_in = w_imm;
    else if (w_re)
      bus.reg_in = bus.mem_addr[0] ? bus.mem_out[2*DATA_W-1:DATA_W] : bus.mem_out[DATA_W-1:0];
  end

  // Byte store is a read-merge: the untouched byte comes back from the addressed word.
  always_comb begin
    if (bus.mem_addr[0])
      bus.mem_in = {bus.reg_o2, bus.mem_out[DATA_W-1:0]};
    else
      bus.mem_in = {bus.mem_out[2*DATA_W-1:DATA_W], bus.reg_o2};
  end

`ifdef SEQ_CU_HALT_EN
  assign halted = (r_state == ST_HALT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_inst  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            r_inst  <= bus.mem_out;
            r_pc    <= r_pc + PC_ONE;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_commit) begin
            if (w_taken && w_wpc)
              r_pc <= bus.alu_out[DATA_W-1:1];
            else if (w_taken && w_ipc)
              r_pc <= w_imm[DATA_W-1:1];
`ifdef SEQ_CU_HALT_EN
            r_state <= halt ? ST_HALT : ST_FETCH;
`else
            r_state <= ST_FETCH;
`endif
          end
        end
        default: begin
`ifdef SEQ_CU_HALT_EN
          r_state <= ST_HALT;
`else
          r_state <= ST_FETCH;
`endif
        end
      endcase
    end
  end

endmodule
